// File: rtl/order_book_sched_if.sv
// Signal bundle between the ITCH parser / order-reference map and order_book_sched.
// slave is the scheduler's view, master is the view of whatever drives it.
interface order_book_sched_if;
   logic        addValidIn;
   logic        addReadyOut;
   logic [15:0] addLocateIn;
   logic [31:0] addPriceIn;
   logic [31:0] addSharesIn;
   logic        addBuySellIn;

   logic        delExecValidIn;
   logic        delExecReadyOut;
   logic [63:0] delExecRefIn;
   logic [31:0] delExecSharesIn;
   logic        delExecIsExecIn;

   logic        lookupReqOut;
   logic [63:0] lookupRefOut;
   logic        lookupRspValidIn;
   logic        lookupHitIn;
   logic [15:0] lookupLocateIn;
   logic [31:0] lookupPriceIn;
   logic [31:0] lookupSharesIn;
   logic        lookupBuySellIn;

   logic        bookAddValidOut;
   logic        bookDelExecValidOut;
   logic [15:0] bookLocateOut;
   logic [31:0] bookPriceOut;
   logic [31:0] bookSharesOut;
   logic        bookBuySellOut;
   logic [15:0] bookMapLocateOut;
   logic [31:0] bookMapPriceOut;
   logic [31:0] bookMapSharesOut;
   logic        bookMapBuySellOut;
   logic [15:0] missCountOut;

   modport slave (
      input  addValidIn, addLocateIn, addPriceIn, addSharesIn, addBuySellIn,
      input  delExecValidIn, delExecRefIn, delExecSharesIn, delExecIsExecIn,
      input  lookupRspValidIn, lookupHitIn, lookupLocateIn, lookupPriceIn,
      input  lookupSharesIn, lookupBuySellIn,
      output addReadyOut, delExecReadyOut, lookupReqOut, lookupRefOut,
      output bookAddValidOut, bookDelExecValidOut, bookLocateOut, bookPriceOut,
      output bookSharesOut, bookBuySellOut, bookMapLocateOut, bookMapPriceOut,
      output bookMapSharesOut, bookMapBuySellOut, missCountOut
   );

   modport master (
      output addValidIn, addLocateIn, addPriceIn, addSharesIn, addBuySellIn,
      output delExecValidIn, delExecRefIn, delExecSharesIn, delExecIsExecIn,
      output lookupRspValidIn, lookupHitIn, lookupLocateIn, lookupPriceIn,
      output lookupSharesIn, lookupBuySellIn,
      input  addReadyOut, delExecReadyOut, lookupReqOut, lookupRefOut,
      input  bookAddValidOut, bookDelExecValidOut, bookLocateOut, bookPriceOut,
      input  bookSharesOut, bookBuySellOut, bookMapLocateOut, bookMapPriceOut,
      input  bookMapSharesOut, bookMapBuySellOut, missCountOut
   );
endinterface

// File: rtl/order_book_sched.sv
// Orders add and delete/execute messages into order_book, one strobe per cycle, resolving
// each delete/execute's resting order through the order-reference map first.
module order_book_sched #(
   parameter int FIFO_DEPTH     = 4,
   parameter int LOOKUP_TIMEOUT = 16
) (
   input  logic              clkIn,
   input  logic              rstIn,
   order_book_sched_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(LOOKUP_TIMEOUT + 1);
   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, ISSUE} state_t;
   typedef struct packed {
      logic [15:0] loc;
      logic [31:0] price;
      logic [31:0] shares;
      logic        bs;
   } add_t;
   typedef struct packed {
      logic [63:0] ref_no;
      logic [31:0] shares;
      logic        is_exec;
      logic [15:0] snap;
   } del_t;

   function automatic logic [31:0] shares_to_remove(input logic is_exec, input logic [31:0] req,
                                                    input logic [31:0] rest);
      if (is_exec && (req < rest)) return req;
      return rest;
   endfunction

   state_t state, state_n;
   add_t add_mem [FIFO_DEPTH];
   del_t del_mem [FIFO_DEPTH];
   logic [AW:0] add_wr, add_rd, del_wr, del_rd, add_cnt_n, del_cnt_n;
   logic [15:0] add_accept_cnt, add_issue_cnt, push_snap, head_snap;
   logic [TW-1:0] timer;
   logic add_empty, add_push, add_issue, add_wr_en, add_pop;
   logic del_empty, del_push, del_have, del_pop, miss;
   add_t add_head;
   del_t del_head;

   assign add_empty = (add_wr == add_rd);
   assign add_push  = bus.addValidIn & bus.addReadyOut;
   // An add arriving at an empty FIFO is issued straight through
   assign add_head  = add_empty ? add_t'{bus.addLocateIn, bus.addPriceIn, bus.addSharesIn,
                                         bus.addBuySellIn} : add_mem[add_rd[AW-1:0]];
   assign add_issue = (!add_empty || add_push) && (state_n != ISSUE);
   assign add_wr_en = add_push && !(add_empty && add_issue);
   assign add_pop   = add_issue && !add_empty;
   assign add_cnt_n = add_wr - add_rd + {{AW{1'b0}}, add_wr_en} - {{AW{1'b0}}, add_pop};

   // A same-edge add is counted as older than the delete/execute
   assign del_empty = (del_wr == del_rd);
   assign del_push  = bus.delExecValidIn & bus.delExecReadyOut;
   assign push_snap = add_accept_cnt + {15'd0, add_push};
   assign del_head  = del_mem[del_rd[AW-1:0]];
   assign head_snap = del_empty ? push_snap : del_head.snap;
   assign del_have  = !del_empty || del_push;
   assign del_cnt_n = del_wr - del_rd + {{AW{1'b0}}, del_push} - {{AW{1'b0}}, del_pop};

   always_comb begin
      state_n = state;
      del_pop = 1'b0;
      miss    = 1'b0;
      case (state)
         IDLE:  if (del_have && (head_snap == add_issue_cnt)) state_n = REQ;
         REQ:   state_n = WAIT;
         WAIT: begin
            if (bus.lookupRspValidIn && bus.lookupHitIn) begin
               state_n = ISSUE;
            end else if (bus.lookupRspValidIn || (timer == TW'(LOOKUP_TIMEOUT - 1))) begin
               del_pop = 1'b1;
               miss    = 1'b1;
               state_n = IDLE;
            end
         end
         ISSUE: begin
            del_pop = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clkIn) begin
      if (add_wr_en) add_mem[add_wr[AW-1:0]] <= add_t'{bus.addLocateIn, bus.addPriceIn,
                                                       bus.addSharesIn, bus.addBuySellIn};
      if (del_push) del_mem[del_wr[AW-1:0]] <= del_t'{bus.delExecRefIn, bus.delExecSharesIn,
                                                      bus.delExecIsExecIn, push_snap};
   end

   always_ff @(posedge clkIn or negedge rstIn) begin
      if (!rstIn) begin
         state                   <= IDLE;
         timer                   <= '0;
         add_wr                  <= '0;
         add_rd                  <= '0;
         del_wr                  <= '0;
         del_rd                  <= '0;
         add_accept_cnt          <= '0;
         add_issue_cnt           <= '0;
         bus.addReadyOut         <= 1'b0;
         bus.delExecReadyOut     <= 1'b0;
         bus.lookupReqOut        <= 1'b0;
         bus.lookupRefOut        <= '0;
         bus.bookAddValidOut     <= 1'b0;
         bus.bookDelExecValidOut <= 1'b0;
         bus.bookLocateOut       <= '0;
         bus.bookPriceOut        <= '0;
         bus.bookSharesOut       <= '0;
         bus.bookBuySellOut      <= 1'b0;
         bus.bookMapLocateOut    <= '0;
         bus.bookMapPriceOut     <= '0;
         bus.bookMapSharesOut    <= '0;
         bus.bookMapBuySellOut   <= 1'b0;
         bus.missCountOut        <= '0;
      end else begin
         state               <= state_n;
         add_wr              <= add_wr + {{AW{1'b0}}, add_wr_en};
         add_rd              <= add_rd + {{AW{1'b0}}, add_pop};
         del_wr              <= del_wr + {{AW{1'b0}}, del_push};
         del_rd              <= del_rd + {{AW{1'b0}}, del_pop};
         add_accept_cnt      <= add_accept_cnt + {15'd0, add_push};
         add_issue_cnt       <= add_issue_cnt + {15'd0, add_issue};
         bus.addReadyOut     <= (add_cnt_n != FULL);
         bus.delExecReadyOut <= (del_cnt_n != FULL);
         if (state == REQ) timer <= '0;
         else if (state == WAIT) timer <= timer + 1'b1;
         bus.lookupReqOut        <= (state_n == REQ);
         bus.bookAddValidOut     <= add_issue;
         bus.bookDelExecValidOut <= (state_n == ISSUE);
         if ((state == IDLE) && (state_n == REQ))
            bus.lookupRefOut <= del_empty ? bus.delExecRefIn : del_head.ref_no;
         if (miss && (bus.missCountOut != 16'hFFFF))
            bus.missCountOut <= bus.missCountOut + 16'd1;
         // Add issue and entry to ISSUE are mutually exclusive, so book fields have one writer
         if (add_issue) begin
            bus.bookLocateOut  <= add_head.loc;
            bus.bookPriceOut   <= add_head.price;
            bus.bookSharesOut  <= add_head.shares;
            bus.bookBuySellOut <= add_head.bs;
         end else if ((state == WAIT) && (state_n == ISSUE)) begin
            bus.bookLocateOut     <= bus.lookupLocateIn;
            bus.bookPriceOut      <= bus.lookupPriceIn;
            bus.bookSharesOut     <= shares_to_remove(del_head.is_exec, del_head.shares,
                                                      bus.lookupSharesIn);
            bus.bookBuySellOut    <= bus.lookupBuySellIn;
            bus.bookMapLocateOut  <= bus.lookupLocateIn;
            bus.bookMapPriceOut   <= bus.lookupPriceIn;
            bus.bookMapSharesOut  <= bus.lookupSharesIn;
            bus.bookMapBuySellOut <= bus.lookupBuySellIn;
         end
      end
   end
endmodule

// File: tb/tb_order_book_sched.sv
// Scoreboard bench for order_book_sched: stimulus queues expected strobes, a negedge
// monitor pops and compares them, and a scripted map model answers lookups.
module tb_order_book_sched;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   order_book_sched_if bus();
   order_book_sched #(.FIFO_DEPTH(4), .LOOKUP_TIMEOUT(16)) dut (
      .clkIn(clk), .rstIn(rst_n), .bus(bus));

   typedef struct packed {
      logic [15:0] loc;
      logic [31:0] price;
      logic [31:0] shares;
      logic        bs;
   } fields_t;
   typedef struct packed { fields_t book; fields_t map; } dexp_t;
   typedef struct packed { logic [63:0] ref_no; logic [31:0] need; } look_t;
   typedef struct { int dly; bit respond; bit hit; fields_t f; } plan_t;

   fields_t add_q[$];
   dexp_t   del_q[$];
   look_t   look_q[$];
   plan_t   plan_q[$];
   int total = 0, bad = 0;
   int adds_sent = 0, adds_seen = 0;
   int late_req = 0, late_done = 0;
   bit arm_full = 0, full_seen = 0;
   fields_t got_a, exp_a;
   dexp_t got_d, exp_d;
   look_t exp_l;
   plan_t cur_p;

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic any_output();
      return |{bus.addReadyOut, bus.delExecReadyOut, bus.lookupReqOut, bus.lookupRefOut,
               bus.bookAddValidOut, bus.bookDelExecValidOut, bus.bookLocateOut, bus.bookPriceOut,
               bus.bookSharesOut, bus.bookBuySellOut, bus.bookMapLocateOut, bus.bookMapPriceOut,
               bus.bookMapSharesOut, bus.bookMapBuySellOut, bus.missCountOut};
   endfunction

   // Monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (arm_full && !bus.delExecReadyOut) full_seen = 1;
         if (bus.bookAddValidOut || bus.bookDelExecValidOut)
            check("strobe_overlap", bus.bookAddValidOut & bus.bookDelExecValidOut, 0);
         if (bus.lookupReqOut) begin
            if (look_q.size() == 0) check("unexpected_lookup", 1, 0);
            else begin
               exp_l = look_q.pop_front();
               check("lookup_ref", bus.lookupRefOut, exp_l.ref_no);
               check("lookup_after_older_adds", adds_seen >= int'(exp_l.need), 1);
            end
         end
         if (bus.bookAddValidOut) begin
            got_a = '{bus.bookLocateOut, bus.bookPriceOut, bus.bookSharesOut, bus.bookBuySellOut};
            if (add_q.size() == 0) check("unexpected_add", got_a, 0);
            else begin
               exp_a = add_q.pop_front();
               check("add_fields", got_a, exp_a);
            end
            adds_seen++;
         end
         if (bus.bookDelExecValidOut) begin
            got_d = '{'{bus.bookLocateOut, bus.bookPriceOut, bus.bookSharesOut, bus.bookBuySellOut},
                      '{bus.bookMapLocateOut, bus.bookMapPriceOut, bus.bookMapSharesOut,
                        bus.bookMapBuySellOut}};
            if (del_q.size() == 0) check("unexpected_delexec", got_d, 0);
            else begin
               exp_d = del_q.pop_front();
               check("delexec_fields", got_d, exp_d);
            end
         end
      end
   end

   // Order-reference map model
   initial begin
      bus.lookupRspValidIn = 0; bus.lookupHitIn = 0; bus.lookupLocateIn = 0;
      bus.lookupPriceIn = 0; bus.lookupSharesIn = 0; bus.lookupBuySellIn = 0;
      forever begin
         @(negedge clk);
         if (late_req != late_done) begin
            late_done = late_req;
            bus.lookupRspValidIn = 1; bus.lookupHitIn = 1; bus.lookupLocateIn = 16'h77;
            bus.lookupPriceIn = 777; bus.lookupSharesIn = 77; bus.lookupBuySellIn = 1;
            @(negedge clk);
            bus.lookupRspValidIn = 0; bus.lookupHitIn = 0;
         end else if (rst_n && bus.lookupReqOut) begin
            check("plan_available", plan_q.size() != 0, 1);
            if (plan_q.size() != 0) begin
               cur_p = plan_q.pop_front();
               if (cur_p.respond) begin
                  repeat (cur_p.dly) @(negedge clk);
                  bus.lookupRspValidIn = 1; bus.lookupHitIn = cur_p.hit;
                  bus.lookupLocateIn = cur_p.f.loc; bus.lookupPriceIn = cur_p.f.price;
                  bus.lookupSharesIn = cur_p.f.shares; bus.lookupBuySellIn = cur_p.f.bs;
                  @(negedge clk);
                  bus.lookupRspValidIn = 0; bus.lookupHitIn = 0;
               end
            end
         end
      end
   end

   task automatic send_add(input logic [15:0] loc, input logic [31:0] price,
                           input logic [31:0] shares, input logic bs);
      int n = 0;
      @(negedge clk);
      bus.addValidIn = 1; bus.addLocateIn = loc; bus.addPriceIn = price;
      bus.addSharesIn = shares; bus.addBuySellIn = bs;
      while (!bus.addReadyOut && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) begin
         check("add_accept_timeout", 1, 0);
         bus.addValidIn = 0;
         return;
      end
      @(posedge clk);
      add_q.push_back('{loc, price, shares, bs});
      adds_sent++;
      #1 bus.addValidIn = 0;
   endtask

   task automatic send_del(input logic [63:0] ref_no, input logic [31:0] shares,
                           input logic is_exec, input plan_t p, input logic [31:0] exp_shares);
      int n = 0;
      plan_q.push_back(p);
      @(negedge clk);
      bus.delExecValidIn = 1; bus.delExecRefIn = ref_no;
      bus.delExecSharesIn = shares; bus.delExecIsExecIn = is_exec;
      while (!bus.delExecReadyOut && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) begin
         check("del_accept_timeout", 1, 0);
         bus.delExecValidIn = 0;
         return;
      end
      @(posedge clk);
      #1 bus.delExecValidIn = 0;
      look_q.push_back('{ref_no, 32'(adds_sent)});
      if (p.respond && p.hit)
         del_q.push_back('{'{p.f.loc, p.f.price, exp_shares, p.f.bs}, p.f});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.addValidIn = 0; bus.addLocateIn = 0; bus.addPriceIn = 0; bus.addSharesIn = 0;
      bus.addBuySellIn = 0; bus.delExecValidIn = 0; bus.delExecRefIn = 0;
      bus.delExecSharesIn = 0; bus.delExecIsExecIn = 0;
      repeat (3) @(negedge clk);
      check("reset_outputs_zero", any_output(), 0);
      check("reset_ready", {bus.addReadyOut, bus.delExecReadyOut}, 2'b00);
      rst_n = 1;
      @(negedge clk);
      check("ready_after_release", {bus.addReadyOut, bus.delExecReadyOut}, 2'b11);

      send_add(16'd5, 32'd1000, 32'd100, 1'b1);
      @(negedge clk);
      check("add_latency", bus.bookAddValidOut, 1);
      repeat (2) @(negedge clk);

      send_del(64'h1234, 32'd0, 1'b0, '{2, 1, 1, '{16'd7, 32'd2000, 32'd300, 1'b0}}, 32'd300);
      @(negedge clk);
      check("req_latency", bus.lookupReqOut, 1);
      repeat (8) @(negedge clk);

      send_del(64'h2001, 32'd500, 1'b1, '{2, 1, 1, '{16'd9, 32'd2500, 32'd300, 1'b1}}, 32'd300);
      repeat (8) @(negedge clk);
      send_del(64'h2002, 32'd50, 1'b1, '{2, 1, 1, '{16'd9, 32'd2500, 32'd300, 1'b1}}, 32'd50);
      repeat (8) @(negedge clk);

      fork
         send_add(16'd11, 32'd1100, 32'd10, 1'b0);
         send_del(64'h55, 32'd0, 1'b0, '{2, 1, 1, '{16'd3, 32'd1500, 32'd40, 1'b1}}, 32'd40);
      join
      for (int i = 0; i < 4; i++)
         send_add(16'(20 + i), 32'(2000 + i), 32'(1 + i), 1'(i));
      repeat (10) @(negedge clk);

      arm_full = 1;
      for (int i = 0; i < 6; i++)
         send_del(64'h100 + 64'(i), 32'd0, 1'b0,
                  '{3, 1, 1, '{16'(30 + i), 32'(3000 + i), 32'(10 + i), 1'b0}}, 32'(10 + i));
      repeat (40) @(negedge clk);
      arm_full = 0;
      check("del_ready_low_when_full", full_seen, 1);

      send_del(64'h3000, 32'd0, 1'b0, '{2, 1, 0, '{16'd1, 32'd1, 32'd1, 1'b0}}, 32'd0);
      repeat (10) @(negedge clk);
      check("miss_count_after_miss", bus.missCountOut, 16'd1);

      send_del(64'h3001, 32'd0, 1'b0, '{0, 0, 0, '{16'd0, 32'd0, 32'd0, 1'b0}}, 32'd0);
      repeat (12) @(negedge clk);
      check("no_early_timeout", bus.missCountOut, 16'd1);
      repeat (20) @(negedge clk);
      check("miss_count_after_timeout", bus.missCountOut, 16'd2);

      check("add_queue_drained", add_q.size(), 0);
      check("del_queue_drained", del_q.size(), 0);
      check("lookup_queue_drained", look_q.size(), 0);

      send_del(64'h4000, 32'd0, 1'b0, '{0, 0, 0, '{16'd0, 32'd0, 32'd0, 1'b0}}, 32'd0);
      repeat (4) @(negedge clk);
      rst_n = 0;
      @(negedge clk);
      check("mid_reset_outputs_zero", any_output(), 0);
      rst_n = 1;
      late_req++;
      repeat (8) @(negedge clk);
      check("late_rsp_miss_count", bus.missCountOut, 16'd0);
      check("late_rsp_no_strobe", {bus.bookAddValidOut, bus.bookDelExecValidOut}, 2'b00);
      check("plan_queue_drained", plan_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
